// File: rtl/rcas8_sync.sv
// 8-bit ripple-carry adder/subtractor with a single registered output stage.
// mode=0 adds A1+A2; mode=1 subtracts as A1 + ~A2 + 1.
module rcas8_sync (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic [7:0] A1,
   input  logic [7:0] A2,
   input  logic       mode,
   output logic [7:0] S,
   output logic       C,
   output logic       V,
   output logic       out_valid
);

   localparam int unsigned W = 8;

   logic [W-1:0] b_c;
   logic [W-1:0] sum_c;
   logic [W:0]   carry_c;

   logic [W-1:0] s_q, s_d;
   logic         c_q, c_d;
   logic         v_q, v_d;
   logic         out_valid_q, out_valid_d;

   // Chain of full-adder cells; each carry feeds the next cell, no lookahead.
   always_comb begin
      b_c        = '0;
      sum_c      = '0;
      carry_c    = '0;
      carry_c[0] = mode;
      for (int unsigned i = 0; i < W; i++) begin
         b_c[i]       = A2[i] ^ mode;
         sum_c[i]     = A1[i] ^ b_c[i] ^ carry_c[i];
         carry_c[i+1] = (A1[i] & b_c[i]) | (carry_c[i] & (A1[i] ^ b_c[i]));
      end
   end

   // Capture a new result on valid input; otherwise hold the data and drop valid.
   always_comb begin
      s_d         = s_q;
      c_d         = c_q;
      v_d         = v_q;
      out_valid_d = 1'b0;
      if (in_valid) begin
         s_d         = sum_c;
         c_d         = carry_c[W];
         v_d         = carry_c[W] ^ carry_c[W-1];
         out_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s_q         <= '0;
         c_q         <= 1'b0;
         v_q         <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         s_q         <= s_d;
         c_q         <= c_d;
         v_q         <= v_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign S         = s_q;
   assign C         = c_q;
   assign V         = v_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rcas8_sync.sv
// Directed bench for rcas8_sync: vector table of hand-computed results plus
// reset, hold and mid-stream reset sequences.
module tb_rcas8_sync;

   typedef struct {
      logic [7:0] a1;
      logic [7:0] a2;
      logic       mode;
      logic [7:0] exp_s;
      logic       exp_c;
      logic       exp_v;
   } vec_t;

   localparam int unsigned NVEC = 12;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [7:0] A1;
   logic [7:0] A2;
   logic       mode;
   logic [7:0] S;
   logic       C;
   logic       V;
   logic       out_valid;

   int n_tests;
   int n_fail;
   vec_t vecs [NVEC];

   rcas8_sync dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .A1        (A1),
      .A2        (A2),
      .mode      (mode),
      .S         (S),
      .C         (C),
      .V         (V),
      .out_valid (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [7:0] es, input logic ec,
                            input logic ev, input logic eov);
      check({tag, ".S"}, S, es);
      check({tag, ".C"}, 8'(C), 8'(ec));
      check({tag, ".V"}, 8'(V), 8'(ev));
      check({tag, ".out_valid"}, 8'(out_valid), 8'(eov));
   endtask

   task automatic drive(input logic rst, input logic vld, input logic [7:0] a,
                        input logic [7:0] b, input logic m);
      @(negedge clk);
      rst_n    = rst;
      in_valid = vld;
      A1       = a;
      A2       = b;
      mode     = m;
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;

      vecs[0]  = '{8'h03, 8'h02, 1'b0, 8'h05, 1'b0, 1'b0};
      vecs[1]  = '{8'h05, 8'h03, 1'b1, 8'h02, 1'b1, 1'b0};
      vecs[2]  = '{8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0};
      vecs[3]  = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
      vecs[4]  = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
      vecs[5]  = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
      vecs[6]  = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 1'b0};
      vecs[7]  = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
      vecs[8]  = '{8'h7F, 8'hFF, 1'b1, 8'h80, 1'b0, 1'b1};
      vecs[9]  = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
      vecs[10] = '{8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1, 1'b0};
      vecs[11] = '{8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0};

      // Reset held two cycles while a valid operation is presented.
      rst_n    = 1'b0;
      in_valid = 1'b1;
      A1       = 8'hFF;
      A2       = 8'h01;
      mode     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);

      // Back-to-back valid vectors, mode changing freely between cycles.
      for (int i = 0; i < int'(NVEC); i++) begin
         drive(1'b1, 1'b1, vecs[i].a1, vecs[i].a2, vecs[i].mode);
         check_all($sformatf("vec%0d", i), vecs[i].exp_s, vecs[i].exp_c,
                   vecs[i].exp_v, 1'b1);
      end

      // Hold: idle cycles keep the last result and drop out_valid.
      drive(1'b1, 1'b1, 8'h7F, 8'h01, 1'b0);
      check_all("pre_hold", 8'h80, 1'b0, 1'b1, 1'b1);
      drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
      check_all("hold1", 8'h80, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 8'h33, 8'h44, 1'b0);
      check_all("hold2", 8'h80, 1'b0, 1'b1, 1'b0);

      // Reset wins over a simultaneous valid input.
      drive(1'b0, 1'b1, 8'h03, 8'h02, 1'b0);
      check_all("rst_mid", 8'h00, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 8'h03, 8'h02, 1'b0);
      check_all("post_rst_idle", 8'h00, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 8'h05, 8'h03, 1'b1);
      check_all("recover", 8'h02, 1'b1, 1'b0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
